// File: rtl/word_pattern_detector.sv
// Streaming word matcher: compares the most recent accepted letters against a
// programmable pattern with '?' wildcards and optional case folding.
module word_pattern_detector #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 letter,
  input  logic                       letter_vld,
  input  logic                       nocase,
  input  logic                       cfg_we,
  input  logic [$clog2(MAX_LEN)-1:0] cfg_addr,
  input  logic [7:0]                 cfg_data,
  input  logic                       len_we,
  input  logic [$clog2(MAX_LEN):0]   len_data,
  input  logic                       cnt_clr,
  output logic                       eurika,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = AW + 1;

  typedef logic [7:0] char_t;

  char_t             pat_q  [MAX_LEN];
  char_t             pat_d  [MAX_LEN];
  char_t             hist_q [MAX_LEN];
  char_t             hist_d [MAX_LEN];
  char_t             win    [MAX_LEN];
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     fill_q, fill_d, fill_inc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              eurika_q, eurika_d;
  logic              cfg_any, accept, mismatch, hit;

  function automatic char_t reset_char(input int idx);
    char_t c;
    c = 8'h3F;
    if (MAX_LEN == 8) begin
      case (idx)
        0:       c = 8'h48; // H
        1:       c = 8'h4F; // O
        2:       c = 8'h4D; // M
        3:       c = 8'h45; // E
        4:       c = 8'h57; // W
        5:       c = 8'h4F; // O
        6:       c = 8'h52; // R
        7:       c = 8'h4B; // K
        default: c = 8'h3F;
      endcase
    end
    return c;
  endfunction

  function automatic char_t fold(input char_t c, input logic nc);
    return (nc && c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

  function automatic logic ch_match(input char_t p, input char_t c, input logic nc);
    return (p == 8'h3F) || (fold(p, nc) == fold(c, nc));
  endfunction

  // NOTE: the pattern file is small and has a defined power-up value, so it is
  // reset like any other register rather than left as uninitialised storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        pat_q[i]  <= reset_char(i);
        hist_q[i] <= 8'h00;
      end
      len_q    <= LW'(MAX_LEN);
      fill_q   <= '0;
      cnt_q    <= '0;
      eurika_q <= 1'b0;
    end else begin
      pat_q    <= pat_d;
      hist_q   <= hist_d;
      len_q    <= len_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      eurika_q <= eurika_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    pat_d    = pat_q;
    hist_d   = hist_q;
    len_d    = len_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    mismatch = 1'b0;

    cfg_any = cfg_we | len_we;
    accept  = letter_vld & ~cfg_any;

    // win[0] is the letter on offer, win[j] the one accepted j letters earlier.
    win[0] = letter;
    for (int j = 1; j < MAX_LEN; j++) win[j] = hist_q[j-1];

    fill_inc = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + LW'(1);

    // Pattern index i lines up with window slot j when i + j + 1 == len.
    for (int i = 0; i < MAX_LEN; i++) begin
      for (int j = 0; j < MAX_LEN; j++) begin
        if ((i + j + 1 == int'(len_q)) && !ch_match(pat_q[i], win[j], nocase))
          mismatch = 1'b1;
      end
    end

    hit      = accept && (fill_inc >= len_q) && !mismatch;
    eurika_d = hit;

    if (cfg_we && (int'(cfg_addr) < MAX_LEN)) pat_d[cfg_addr] = cfg_data;

    if (len_we) begin
      if (len_data <= LW'(1))            len_d = LW'(1);
      else if (len_data > LW'(MAX_LEN))  len_d = LW'(MAX_LEN);
      else                               len_d = len_data;
    end

    if (cfg_any) begin
      fill_d = '0;
    end else if (accept) begin
      hist_d = win;
      fill_d = fill_inc;
    end

    if (cnt_clr)                   cnt_d = '0;
    else if (hit && cnt_q != '1)   cnt_d = cnt_q + CNT_W'(1);
  end

  assign eurika    = eurika_q;
  assign match_cnt = cnt_q;

endmodule

// File: doc/word_pattern_detector.md
WORD_PATTERN_DETECTOR -- requirements
Module: word_pattern_detector

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in characters (range 2..16).
REQ-002 Parameter CNT_W, default 8: width of the match counter.
REQ-003 The block SHALL have one clock, clk; reset is rst, synchronous, active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 letter  input  8  ASCII character, sampled only when letter_vld=1.
REQ-007 letter_vld  input  1  qualifies letter for one cycle.
REQ-008 nocase  input  1  1 = case-insensitive compare for A-Z/a-z.
REQ-009 cfg_we  input  1  pattern character write strobe.
REQ-010 cfg_addr  input  $clog2(MAX_LEN)  pattern character index (0 = first character).
REQ-011 cfg_data  input  8  pattern character value.
REQ-012 len_we  input  1  pattern length write strobe.
REQ-013 len_data  input  $clog2(MAX_LEN)+1  new pattern length.
REQ-014 cnt_clr  input  1  clears match_cnt.
REQ-015 eurika  output  1  one-cycle match pulse, registered.
REQ-016 match_cnt  output  CNT_W  saturating count of matches.

Function
REQ-017 The pattern SHALL be held in a register file pat[0..MAX_LEN-1] plus a length register len.
REQ-018 The block SHALL keep a history shift register of the last MAX_LEN accepted letters and a fill counter saturating at MAX_LEN.
REQ-019 On a cycle with letter_vld=1 and no configuration write, the block SHALL shift letter into the history and increment fill.
REQ-020 A match SHALL be declared on an accepted letter when fill (including that letter) is >= len and the last len accepted letters, oldest first, equal pat[0..len-1].
REQ-021 pat[i]=8'h3F ('?') SHALL match any character.
REQ-022 With nocase=1, letters 8'h41-8'h5A and 8'h61-8'h7A SHALL compare equal to their case counterparts; all other codes compare exactly.
REQ-023 Detection SHALL be overlapping: every accepted letter that completes a match produces a match, regardless of earlier matches.
REQ-024 eurika SHALL be 1 for exactly the cycle after the posedge that accepted the completing letter, and 0 otherwise; a match on back-to-back letters gives back-to-back pulses.
REQ-025 Cycles with letter_vld=0 SHALL leave history, fill and match_cnt unchanged and drive eurika=0 next cycle.
REQ-026 cfg_we=1 SHALL write pat[cfg_addr]<=cfg_data; writes with cfg_addr>=MAX_LEN SHALL be ignored.
REQ-027 len_we=1 SHALL set len<=len_data, clamped: 0 and 1 become 1, values above MAX_LEN become MAX_LEN.
REQ-028 Any cycle with cfg_we=1 or len_we=1 SHALL clear fill to 0, drop the letter offered that cycle, and force eurika=0 next cycle.
REQ-029 match_cnt SHALL increment on each match and hold at 2^CNT_W-1 without wrapping.
REQ-030 If cnt_clr=1, match_cnt SHALL become 0 that cycle, even if a match occurs in the same cycle (clear wins); eurika still pulses.

Reset
REQ-031 On rst=1 at posedge: eurika=0, match_cnt=0, fill=0, history=8'h00, len=MAX_LEN, and pat reset to "HOMEWORK" for MAX_LEN=8 (otherwise all '?').
REQ-032 rst SHALL override all other inputs in the same cycle; a rst mid-sequence discards partial matches.

Verification
REQ-033 Reset, feed "HOMEWORK" one letter per cycle -> eurika=1 only in the cycle after 'K' is accepted, match_cnt=1.
REQ-034 len=3, pattern "ABA", feed "ABABA" -> pulses after the 3rd and 5th letters, match_cnt=2.
REQ-035 Pattern "H?ME", nocase=1, feed "hOmE" with letter_vld gapped (1,0,1,1,0,1) -> one pulse after 'E', none during gaps; nocase=0 with the same input -> no pulse.
REQ-036 Feed "HOMEW", cfg_we in the next cycle, then "ORK" -> no pulse (fill cleared).
REQ-037 CNT_W=2, 5 consecutive matches -> match_cnt sticks at 3; cnt_clr coincident with a 6th match -> match_cnt=0, eurika=1.
REQ-038 rst asserted after "HOMEWOR", then "K" -> no pulse; rst again -> all outputs 0.
